mem_port_arbiter: RTL and testbench

Arbitrates the single-ported unified instruction/data memory of the RV32I core between the fetch stage and the load/store stage. Each cycle it grants at most one requester, drives the memory port from the winner, tracks the one-cycle read latency of the synchronous memory, and routes the returned word back to its owner. It emits stall signals so the PC register and the datapath hold while a request is denied. Starvation of fetch is bounded by a wait counter.

---
 rtl/mem_port_arbiter_pkg.sv | 10 +
 rtl/mem_port_arbiter_fetch_starve_ctr.sv | 18 +
 rtl/mem_port_arbiter.sv | 70 +++++++
 tb/tb_mem_port_arbiter.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg: response-owner encoding and the word-access funct3 shared by the arbiter.
package mem_port_arbiter_pkg;
    typedef enum logic [1:0] {
        RSP_NONE = 2'd0,
        RSP_IF   = 2'd1,
        RSP_DRD  = 2'd2,
        RSP_DWR  = 2'd3
    } rsp_t;
    localparam logic [2:0] FUNCT3_WORD = 3'b010;
endpackage

// File: rtl/mem_port_arbiter_fetch_starve_ctr.sv
// fetch_starve_ctr: counts consecutive denied fetch cycles and raises force_if at max_wait.
module fetch_starve_ctr #(
    parameter int MAX_WAIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic req,
    input  logic gnt,
    output logic force_if
);
    localparam logic [3:0] MAX = 4'(MAX_WAIT);
    logic [3:0] cnt;
    assign force_if = cnt == MAX;
    always_ff @(posedge clk) begin
        if (rst || !req || gnt) cnt <= '0;
        else if (cnt != MAX) cnt <= cnt + 4'd1;
    end
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one synchronous memory port between fetch and load/store, data first with bounded fetch starvation.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W   = 10,
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    input  logic [2:0]        d_funct3,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [2:0]        mem_funct3,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              if_stall,
    output logic              d_stall
);
    logic force_if, d_win, d_load;
    rsp_t rsp_q, rsp_d;
    logic [DATA_W-1:0] if_hold, d_hold;

    fetch_starve_ctr #(.MAX_WAIT(MAX_WAIT)) u_ctr (
        .clk(clk), .rst(rst), .req(if_req), .gnt(if_gnt), .force_if(force_if)
    );

    assign d_win      = d_req & ~(if_req & force_if);
    assign if_gnt     = ~rst & if_req & ~d_win;
    assign d_gnt      = ~rst & d_win;
    assign if_stall   = if_req & ~if_gnt;
    assign d_stall    = d_req & ~d_gnt;
    assign mem_en     = if_gnt | d_gnt;
    assign mem_we     = d_gnt & d_we;
    assign mem_addr   = if_gnt ? if_addr : d_gnt ? d_addr : '0;
    assign mem_wdata  = d_gnt ? d_wdata : '0;
    assign mem_funct3 = if_gnt ? FUNCT3_WORD : d_gnt ? d_funct3 : 3'b000;
    assign rsp_d      = if_gnt ? RSP_IF : d_gnt ? (d_we ? RSP_DWR : RSP_DRD) : RSP_NONE;
    // A response still in flight when reset is seen is dropped, not delivered.
    assign if_rvalid  = ~rst & (rsp_q == RSP_IF);
    assign d_load     = ~rst & (rsp_q == RSP_DRD);
    assign d_rvalid   = ~rst & (rsp_q == RSP_DRD || rsp_q == RSP_DWR);
    assign if_rdata   = if_rvalid ? mem_rdata : if_hold;
    assign d_rdata    = d_load ? mem_rdata : d_hold;

    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_q   <= RSP_NONE;
            if_hold <= '0;
            d_hold  <= '0;
        end else begin
            rsp_q <= rsp_d;
            if (if_rvalid) if_hold <= mem_rdata;
            if (d_load) d_hold <= mem_rdata;
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed checks of arbitration, latency, starvation bound, store/fetch and reset.
module tb_mem_port_arbiter;
    logic        clk = 0, rst;
    logic        if_req, d_req, d_we;
    logic [9:0]  if_addr, d_addr;
    logic [31:0] d_wdata;
    logic [2:0]  d_funct3;
    logic        if_gnt, if_rvalid, d_gnt, d_rvalid, mem_en, mem_we, if_stall, d_stall;
    logic [31:0] if_rdata, d_rdata, mem_wdata, mem_rdata = 0;
    logic [9:0]  mem_addr;
    logic [2:0]  mem_funct3;
    logic [31:0] mem [256];
    int checks = 0, failures = 0;

    always #5 clk = ~clk;

    mem_port_arbiter dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_funct3(d_funct3),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_funct3(mem_funct3), .mem_rdata(mem_rdata), .if_stall(if_stall), .d_stall(d_stall)
    );

    // Word-wide synchronous memory stub with one-cycle read latency.
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) mem[mem_addr[9:2]] <= mem_wdata;
            mem_rdata <= mem[mem_addr[9:2]];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        mem[1]  = 32'h00500093;
        mem[64] = 32'hDEADBEEF;
        rst = 1; if_req = 0; d_req = 0; d_we = 0; if_addr = 0; d_addr = 0; d_wdata = 0; d_funct3 = 3'b010;
        step(); step();
        if_req = 1; if_addr = 10'h004;
        #1;
        chk("rst_if_gnt", {31'b0, if_gnt}, 0);
        chk("rst_mem_en", {31'b0, mem_en}, 0);
        if_req = 0;
        step();
        rst = 0;
        #1;
        chk("rst_if_rvalid", {31'b0, if_rvalid}, 0);
        chk("rst_d_rvalid", {31'b0, d_rvalid}, 0);
        chk("rst_if_rdata", if_rdata, 0);
        chk("rst_d_rdata", d_rdata, 0);

        if_req = 1; if_addr = 10'h004;
        #1;
        chk("f_if_gnt", {31'b0, if_gnt}, 1);
        chk("f_mem_addr", {22'b0, mem_addr}, 32'h004);
        chk("f_mem_we", {31'b0, mem_we}, 0);
        chk("f_mem_funct3", {29'b0, mem_funct3}, 3'b010);
        chk("f_if_stall", {31'b0, if_stall}, 0);
        step();
        if_req = 0;
        #1;
        chk("f_if_rvalid", {31'b0, if_rvalid}, 1);
        chk("f_if_rdata", if_rdata, 32'h00500093);

        if_req = 1; if_addr = 10'h008; d_req = 1; d_addr = 10'h100;
        #1;
        chk("ld_d_gnt", {31'b0, d_gnt}, 1);
        chk("ld_if_gnt", {31'b0, if_gnt}, 0);
        chk("ld_if_stall", {31'b0, if_stall}, 1);
        chk("ld_mem_addr", {22'b0, mem_addr}, 32'h100);
        step();
        if_req = 0; d_req = 0;
        #1;
        chk("ld_d_rvalid", {31'b0, d_rvalid}, 1);
        chk("ld_d_rdata", d_rdata, 32'hDEADBEEF);
        chk("ld_if_rvalid", {31'b0, if_rvalid}, 0);
        step();
        chk("idle_mem_en", {31'b0, mem_en}, 0);
        chk("idle_gnts", {30'b0, if_gnt, d_gnt}, 0);
        chk("idle_stalls", {30'b0, if_stall, d_stall}, 0);
        chk("idle_rvalids", {30'b0, if_rvalid, d_rvalid}, 0);
        chk("idle_if_rdata", if_rdata, 32'h00500093);
        chk("idle_d_rdata", d_rdata, 32'hDEADBEEF);

        if_req = 1; if_addr = 10'h004; d_req = 1; d_addr = 10'h100;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk($sformatf("starve_if_gnt_%0d", k), {31'b0, if_gnt}, (k == 4) ? 1 : 0);
            chk($sformatf("starve_d_stall_%0d", k), {31'b0, d_stall}, (k == 4) ? 1 : 0);
            step();
        end
        #1;
        chk("starve_after_if_gnt", {31'b0, if_gnt}, 0);
        chk("starve_after_if_rvalid", {31'b0, if_rvalid}, 1);
        chk("starve_after_if_rdata", if_rdata, 32'h00500093);
        if_req = 0; d_req = 0;
        step();

        d_req = 1; d_we = 1; d_addr = 10'h040; d_wdata = 32'h12345678;
        #1;
        chk("st_d_gnt", {31'b0, d_gnt}, 1);
        chk("st_mem_we", {31'b0, mem_we}, 1);
        chk("st_mem_wdata", mem_wdata, 32'h12345678);
        step();
        d_req = 0; d_we = 0; if_req = 1; if_addr = 10'h040;
        #1;
        chk("st_d_rvalid", {31'b0, d_rvalid}, 1);
        chk("st_d_rdata", d_rdata, 32'hDEADBEEF);
        chk("st_fetch_gnt", {31'b0, if_gnt}, 1);
        step();
        if_req = 0;
        #1;
        chk("st_fetch_rvalid", {31'b0, if_rvalid}, 1);
        chk("st_fetch_rdata", if_rdata, 32'h12345678);

        if_req = 1; if_addr = 10'h004; d_req = 1; d_addr = 10'h100;
        #1;
        chk("rl_d_gnt", {31'b0, d_gnt}, 1);
        step();
        d_req = 0; rst = 1;
        #1;
        chk("rl_rst_d_rvalid", {31'b0, d_rvalid}, 0);
        chk("rl_rst_d_gnt", {31'b0, d_gnt}, 0);
        chk("rl_rst_if_gnt", {31'b0, if_gnt}, 0);
        step();
        rst = 0; if_req = 0;
        #1;
        chk("rl_d_rvalid", {31'b0, d_rvalid}, 0);
        chk("rl_d_rdata", d_rdata, 0);
        chk("rl_if_rdata", if_rdata, 0);
        chk("rl_wait_cnt", {28'b0, dut.u_ctr.cnt}, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
